conv_accel_top: RTL and testbench



---
 rtl/conv_accel_top.sv | 235 +++++++++++++++++++++++
 tb/tb_conv_accel_top.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_accel_top.sv
// conv_accel_top: single-MAC 2-D convolution accelerator.
// Streams K*K*Ci operand pairs per output pixel/channel and returns one
// accumulated result per (y, x, ch) on the C bus.
// Optional macro CONV_MULT_PIPE_EN: registers the product before the adder
// and adds a one-cycle DRAIN state between MAC and OUT.
module conv_accel_top #(
    parameter int unsigned IO_DATA_WIDTH      = 16,
    parameter int unsigned ACCUMULATION_WIDTH = 32,
    parameter int unsigned EXT_MEM_HEIGHT     = 32,
    parameter int unsigned EXT_MEM_WIDTH      = 32,
    parameter int unsigned FEATURE_MAP_WIDTH  = 128,
    parameter int unsigned FEATURE_MAP_HEIGHT = 128,
    parameter int unsigned INPUT_NB_CHANNELS  = 2,
    parameter int unsigned OUTPUT_NB_CHANNELS = 16
) (
    input  logic                                  clk,
    input  logic                                  arst_n_in,
    input  logic                                  conv_kernel_mode,
    input  logic [1:0]                            conv_stride_mode,
    input  logic [IO_DATA_WIDTH-1:0]              a_input,
    input  logic                                  a_valid,
    output logic                                  a_ready,
    input  logic [IO_DATA_WIDTH-1:0]              b_input,
    input  logic                                  b_valid,
    output logic                                  b_ready,
    output logic [EXT_MEM_WIDTH-1:0]              c_input_output,
    output logic                                  c_valid,
    input  logic                                  c_ready,
    output logic                                  output_valid,
    output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  output_x,
    output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] output_y,
    output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] output_ch,
    input  logic                                  start,
    output logic                                  running
);

    localparam int unsigned XW = $clog2(FEATURE_MAP_WIDTH);
    localparam int unsigned YW = $clog2(FEATURE_MAP_HEIGHT);
    localparam int unsigned CW = $clog2(OUTPUT_NB_CHANNELS);
    localparam int unsigned AW = ACCUMULATION_WIDTH;
    localparam int unsigned PW = 2 * IO_DATA_WIDTH;
    localparam int unsigned TW = $clog2(9 * INPUT_NB_CHANNELS);
    // Coordinate step arithmetic needs headroom for a stride of up to 4.
    localparam int unsigned XE = XW + 3;
    localparam int unsigned YE = YW + 3;

    // Reject parameter sets the datapath cannot represent.
    if (EXT_MEM_WIDTH != ACCUMULATION_WIDTH || EXT_MEM_HEIGHT == 0 ||
        ACCUMULATION_WIDTH < PW) begin : g_bad_cfg
        $error("conv_accel_top: unsupported parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_OUT   = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              k1_q, k1_d;
    logic [2:0]        stride_q, stride_d;
    logic [TW-1:0]     tap_q, tap_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [CW-1:0]     ch_q, ch_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic              running_q, running_d;
    logic              ready_q, ready_d;
    logic              cvalid_q, cvalid_d;
`ifdef CONV_MULT_PIPE_EN
    logic signed [PW-1:0] prod_q, prod_d;
    logic                 pvalid_q, pvalid_d;
    logic                 pfirst_q, pfirst_d;
`endif

    logic signed [PW-1:0] a_ext_c, b_ext_c, prod_c;
    logic                 fire_c, last_tap_c, ch_last_c, x_end_c, y_end_c;
    logic [XE-1:0]        x_step_c;
    logic [YE-1:0]        y_step_c;

    // Operand product, handshake and loop-boundary decodes.
    always_comb begin
        a_ext_c    = PW'($signed(a_input));
        b_ext_c    = PW'($signed(b_input));
        prod_c     = a_ext_c * b_ext_c;
        fire_c     = ready_q & a_valid & b_valid;
        last_tap_c = (tap_q == (k1_q ? TW'(INPUT_NB_CHANNELS - 1)
                                     : TW'(9 * INPUT_NB_CHANNELS - 1)));
        ch_last_c  = (ch_q == CW'(OUTPUT_NB_CHANNELS - 1));
        x_step_c   = XE'(x_q) + XE'(stride_q);
        y_step_c   = YE'(y_q) + YE'(stride_q);
        x_end_c    = (x_step_c >= XE'(FEATURE_MAP_WIDTH));
        y_end_c    = (y_step_c >= YE'(FEATURE_MAP_HEIGHT));
    end

    // Next-state, accumulator and counter update logic.
    always_comb begin
        state_d  = state_q;
        k1_d     = k1_q;
        stride_d = stride_q;
        tap_d    = tap_q;
        x_d      = x_q;
        y_d      = y_q;
        ch_d     = ch_q;
        acc_d    = acc_q;
`ifdef CONV_MULT_PIPE_EN
        prod_d   = prod_q;
        pvalid_d = 1'b0;
        pfirst_d = pfirst_q;
        // The registered product lands one cycle after its tap handshake.
        if (pvalid_q) begin
            acc_d = (pfirst_q ? '0 : acc_q) + AW'(prod_q);
        end
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    k1_d = conv_kernel_mode;
                    case (conv_stride_mode)
                        2'd0:    stride_d = 3'd1;
                        2'd1:    stride_d = 3'd2;
                        default: stride_d = 3'd4;
                    endcase
                    tap_d   = '0;
                    x_d     = '0;
                    y_d     = '0;
                    ch_d    = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                if (fire_c) begin
`ifdef CONV_MULT_PIPE_EN
                    prod_d   = prod_c;
                    pvalid_d = 1'b1;
                    pfirst_d = (tap_q == '0);
`else
                    acc_d = ((tap_q == '0) ? '0 : acc_q) + AW'(prod_c);
`endif
                    if (last_tap_c) begin
                        tap_d = '0;
`ifdef CONV_MULT_PIPE_EN
                        state_d = S_DRAIN;
`else
                        state_d = S_OUT;
`endif
                    end else begin
                        tap_d = tap_q + TW'(1);
                    end
                end
            end
`ifdef CONV_MULT_PIPE_EN
            S_DRAIN: begin
                state_d = S_OUT;
            end
`endif
            S_OUT: begin
                if (c_ready) begin
                    state_d = S_MAC;
                    if (ch_last_c) begin
                        ch_d = '0;
                        if (x_end_c) begin
                            x_d = '0;
                            if (y_end_c) begin
                                y_d     = '0;
                                state_d = S_IDLE;
                            end else begin
                                y_d = YW'(y_step_c);
                            end
                        end else begin
                            x_d = XW'(x_step_c);
                        end
                    end else begin
                        ch_d = ch_q + CW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        running_d = (state_d != S_IDLE);
        ready_d   = (state_d == S_MAC);
        cvalid_d  = (state_d == S_OUT);
    end

    // State and registered outputs; reset aborts any layer in flight.
    always_ff @(posedge clk or posedge arst_n_in) begin
        if (arst_n_in) begin
            state_q   <= S_IDLE;
            k1_q      <= 1'b0;
            stride_q  <= 3'd1;
            tap_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            ch_q      <= '0;
            acc_q     <= '0;
            running_q <= 1'b0;
            ready_q   <= 1'b0;
            cvalid_q  <= 1'b0;
`ifdef CONV_MULT_PIPE_EN
            prod_q    <= '0;
            pvalid_q  <= 1'b0;
            pfirst_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            k1_q      <= k1_d;
            stride_q  <= stride_d;
            tap_q     <= tap_d;
            x_q       <= x_d;
            y_q       <= y_d;
            ch_q      <= ch_d;
            acc_q     <= acc_d;
            running_q <= running_d;
            ready_q   <= ready_d;
            cvalid_q  <= cvalid_d;
`ifdef CONV_MULT_PIPE_EN
            prod_q    <= prod_d;
            pvalid_q  <= pvalid_d;
            pfirst_q  <= pfirst_d;
`endif
        end
    end

    assign a_ready        = ready_q;
    assign b_ready        = ready_q;
    assign c_valid        = cvalid_q;
    assign output_valid   = cvalid_q;
    assign c_input_output = EXT_MEM_WIDTH'(acc_q);
    assign output_x       = x_q;
    assign output_y       = y_q;
    assign output_ch      = ch_q;
    assign running        = running_q;

endmodule

// File: tb/tb_conv_accel_top.sv
// Randomized bench for conv_accel_top on a small map; expected results are
// computed from the tap streams as plain sums of products in loop order.
module tb_conv_accel_top;

    localparam int unsigned IW = 16;
    localparam int unsigned AW = 32;
    localparam int unsigned W  = 5;
    localparam int unsigned H  = 4;
    localparam int unsigned CI = 2;
    localparam int unsigned CO = 3;
    localparam int unsigned XW = $clog2(W);
    localparam int unsigned YW = $clog2(H);
    localparam int unsigned CW = $clog2(CO);
`ifdef CONV_MULT_PIPE_EN
    localparam int OUT_LAT = 2;
`else
    localparam int OUT_LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          kmode;
    logic [1:0]    smode;
    logic [IW-1:0] a_input, b_input;
    logic          a_valid, b_valid, a_ready, b_ready;
    logic [AW-1:0] c_data;
    logic          c_valid, c_ready, output_valid;
    logic [XW-1:0] output_x;
    logic [YW-1:0] output_y;
    logic [CW-1:0] output_ch;
    logic          start, running;

    int checks   = 0;
    int failures = 0;

    conv_accel_top #(
        .IO_DATA_WIDTH      (IW),
        .ACCUMULATION_WIDTH (AW),
        .EXT_MEM_HEIGHT     (32),
        .EXT_MEM_WIDTH      (AW),
        .FEATURE_MAP_WIDTH  (W),
        .FEATURE_MAP_HEIGHT (H),
        .INPUT_NB_CHANNELS  (CI),
        .OUTPUT_NB_CHANNELS (CO)
    ) dut (
        .clk              (clk),
        .arst_n_in        (rst),
        .conv_kernel_mode (kmode),
        .conv_stride_mode (smode),
        .a_input          (a_input),
        .a_valid          (a_valid),
        .a_ready          (a_ready),
        .b_input          (b_input),
        .b_valid          (b_valid),
        .b_ready          (b_ready),
        .c_input_output   (c_data),
        .c_valid          (c_valid),
        .c_ready          (c_ready),
        .output_valid     (output_valid),
        .output_x         (output_x),
        .output_y         (output_y),
        .output_ch        (output_ch),
        .start            (start),
        .running          (running)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Runs one full layer. dmode: 0 random, 1 all -32768, 2 A=x+y / B=2.
    task automatic run_layer(input logic km, input logic [1:0] sm, input int dmode,
                             input bit stray_start, input bit start_at_end);
        logic signed [IW-1:0] aq[$];
        logic signed [IW-1:0] bq[$];
        logic [31:0] eq[$];
        int ex[$], ey[$], ec[$];
        int k, s, taps, nres, ntaps;
        int ti, ri, cyc, lat, hold_left, rnd;
        bit lat_on, hold, resume, consume;
        logic [31:0] snap_d;
        int snap_x, snap_y, snap_c;
        longint acc;
        logic [63:0] acc_bits;
        logic signed [IW-1:0] av, bv;

        k    = km ? 1 : 3;
        s    = (sm == 2'd0) ? 1 : (sm == 2'd1) ? 2 : 4;
        taps = k * k * CI;
        for (int y = 0; y < int'(H); y += s)
            for (int x = 0; x < int'(W); x += s)
                for (int ch = 0; ch < int'(CO); ch++) begin
                    acc = 0;
                    for (int t = 0; t < taps; t++) begin
                        case (dmode)
                            0: begin av = IW'($urandom); bv = IW'($urandom); end
                            1: begin av = -16'sd32768; bv = -16'sd32768; end
                            default: begin av = IW'(x + y); bv = 16'sd2; end
                        endcase
                        aq.push_back(av);
                        bq.push_back(bv);
                        acc += longint'(av) * longint'(bv);
                    end
                    acc_bits = acc;
                    eq.push_back(acc_bits[31:0]);
                    ex.push_back(x);
                    ey.push_back(y);
                    ec.push_back(ch);
                end
        nres  = eq.size();
        ntaps = aq.size();

        @(negedge clk);
        kmode = km;
        smode = sm;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("start_running", 32'(running), 32'd1);
        check_eq("start_a_ready", 32'(a_ready), 32'd1);
        check_eq("start_b_ready", 32'(b_ready), 32'd1);
        // Randomize the mode pins after start to show they were latched.
        kmode = 1'($urandom);
        smode = 2'($urandom);

        ti = 0; ri = 0; cyc = 0; lat = 0; hold_left = 0;
        lat_on = 1'b0; hold = 1'b0; resume = 1'b0;
        snap_d = '0; snap_x = 0; snap_y = 0; snap_c = 0;
        while (ri < nres && cyc < 20000) begin
            if (lat_on) lat++;
            if (resume) begin
                check_eq("resume_a_ready", 32'(a_ready), 32'd1);
                check_eq("resume_c_valid", 32'(c_valid), 32'd0);
                resume = 1'b0;
            end
            start = stray_start && ($urandom_range(0, 30) == 0);

            // Operand side: random valid gaps, real data only when consumed.
            rnd     = int'($urandom_range(0, 9));
            a_valid = (rnd < 6) || (rnd == 7);
            b_valid = (rnd < 6) || (rnd == 8);
            consume = a_ready && a_valid && b_valid && (ti < ntaps);
            if (consume) begin
                a_input = aq[ti];
                b_input = bq[ti];
                ti++;
                if (ti % taps == 0) begin
                    lat_on = 1'b1;
                    lat    = 0;
                end
            end else begin
                a_input = IW'($urandom);
                b_input = IW'($urandom);
            end

            // Result side.
            if (hold && !c_valid) begin
                check_eq("c_valid_held", 32'(c_valid), 32'd1);
                hold = 1'b0;
            end
            check_eq("output_valid_eq", 32'(output_valid), 32'(c_valid));
            if (c_valid) begin
                check_eq("ready_low_in_out", 32'(a_ready | b_ready), 32'd0);
                if (!hold) begin
                    hold   = 1'b1;
                    snap_d = c_data;
                    snap_x = int'(output_x);
                    snap_y = int'(output_y);
                    snap_c = int'(output_ch);
                    if (lat_on) check_eq("out_latency", 32'(lat), 32'(OUT_LAT));
                    lat_on = 1'b0;
                    if ($urandom_range(0, 5) == 0) hold_left = 10;
                end else begin
                    check_eq("hold_data", c_data, snap_d);
                    check_eq("hold_xyc", {8'(output_x), 8'(output_y), 8'(output_ch)},
                             {8'(snap_x), 8'(snap_y), 8'(snap_c)});
                end
                if (hold_left > 0) begin
                    c_ready = 1'b0;
                    hold_left--;
                end else begin
                    c_ready = ($urandom_range(0, 2) != 0);
                end
                if (c_ready) begin
                    check_eq("result_data", c_data, eq[ri]);
                    check_eq("result_x", 32'(output_x), 32'(ex[ri]));
                    check_eq("result_y", 32'(output_y), 32'(ey[ri]));
                    check_eq("result_ch", 32'(output_ch), 32'(ec[ri]));
                    ri++;
                    hold = 1'b0;
                    if (ri < nres) resume = 1'b1;
                    else start = start_at_end;
                end
            end else begin
                c_ready = 1'($urandom);
            end
            @(negedge clk);
            cyc++;
        end

        a_valid = 1'b0;
        b_valid = 1'b0;
        c_ready = 1'b0;
        start   = 1'b0;
        check_eq("layer_results", 32'(ri), 32'(nres));
        check_eq("layer_taps", 32'(ti), 32'(ntaps));
        if (ri < nres) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end else begin
            check_eq("end_running", 32'(running), 32'd0);
            check_eq("end_a_ready", 32'(a_ready), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("idle_no_result", 32'(c_valid), 32'd0);
            check_eq("idle_running", 32'(running), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; kmode = 1'b0; smode = 2'd0; start = 1'b0;
        a_input = '0; b_input = '0; a_valid = 1'b0; b_valid = 1'b0; c_ready = 1'b0;
        #1;
        check_eq("rst_c_valid", 32'(c_valid), 32'd0);
        check_eq("rst_running", 32'(running), 32'd0);
        check_eq("rst_ready", 32'(a_ready | b_ready), 32'd0);
        check_eq("rst_data", c_data, 32'd0);
        check_eq("rst_xyc", 32'({output_x, output_y, output_ch}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_after_rst", 32'(running), 32'd0);

        run_layer(1'b1, 2'd0, 2, 1'b0, 1'b0);  // K=1 S=1, A=x+y, B=2
        run_layer(1'b0, 2'd0, 0, 1'b1, 1'b1);  // K=3 S=1 random, stray starts
        run_layer(1'b0, 2'd1, 1, 1'b0, 1'b0);  // signed wrap to 0x80000000
        run_layer(1'b1, 2'd3, 0, 1'b1, 1'b1);  // K=1 stride mode 3
        run_layer(1'b0, 2'd2, 0, 1'b0, 1'b0);  // K=3 S=4
        run_layer(1'b1, 2'd1, 0, 1'b1, 1'b0);  // K=1 S=2

        // Reset while a result is being presented.
        @(negedge clk);
        kmode = 1'b0; smode = 2'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 200 && !c_valid; n++) begin
            a_valid = 1'b1; b_valid = 1'b1;
            a_input = IW'($urandom); b_input = IW'($urandom);
            @(negedge clk);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        check_eq("pre_rst_c_valid", 32'(c_valid), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_c_valid", 32'(c_valid), 32'd0);
        check_eq("mid_rst_out_valid", 32'(output_valid), 32'd0);
        check_eq("mid_rst_running", 32'(running), 32'd0);
        check_eq("mid_rst_data", c_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("post_rst_idle", 32'({running, c_valid, a_ready}), 32'd0);
        end
        run_layer(1'b1, 2'd2, 2, 1'b0, 1'b0);  // layer after abort

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
